rib2axi_lite: RTL
=================

RIB2AXI_LITE -- requirements
Module: rib2axi_lite

Interface
REQ-001 Parameter: AW, default 32, address width of the RIB and AXI address ports.
REQ-002 Parameter: DW, default 32, data width; only 32 is supported.
REQ-003 The block SHALL have the following ports; reset is rst, synchronous, active-high; clock is clk.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_i  in  1  RIB slave access request.
REQ-007 we_i  in  1  1=write, 0=read; sampled with req_i.
REQ-008 addr_i  in  AW  access address.
REQ-009 wdata_i  in  DW  write data.
REQ-010 rdata_o  out  DW  read data, registered.
REQ-011 hold_o  out  1  stall request to the core while an access is in flight.
REQ-012 err_o  out  1  one-cycle pulse on SLVERR/DECERR response.
REQ-013 awaddr_o/awvalid_o out AW/1; awready_i in 1  AXI write address channel.
REQ-014 wdata_o/wstrb_o/wvalid_o out DW/4/1; wready_i in 1  AXI write data channel.
REQ-015 bresp_i in 2; bvalid_i in 1; bready_o out 1  AXI write response channel.
REQ-016 araddr_o/arvalid_o out AW/1; arready_i in 1  AXI read address channel.
REQ-017 rdata_i in DW; rresp_i in 2; rvalid_i in 1; rready_o out 1  AXI read data channel.
REQ-018 awprot_o/arprot_o  out  3  tied to 3'b000; wstrb_o tied to 4'hF.

Function
REQ-019 The FSM SHALL have states IDLE, WADDR_DATA, WRESP, RADDR, RDATA, DONE.
REQ-020 IDLE: on req_i=1, latch addr_i, wdata_i, we_i; go to WADDR_DATA if we_i=1, else RADDR.
REQ-021 hold_o SHALL be req_i in IDLE (combinational, same cycle), 1 in WADDR_DATA/WRESP/RADDR/RDATA, 0 in DONE.
REQ-022 WADDR_DATA: awvalid_o and wvalid_o SHALL assert together on entry; each deasserts independently after its own valid&ready cycle.
REQ-023 Transition to WRESP SHALL occur the cycle after both AW and W handshakes complete, including when both complete in the same cycle.
REQ-024 WRESP: bready_o=1; on bvalid_i go to DONE; err_o pulses in DONE if bresp_i[1] was 1.
REQ-025 RADDR: arvalid_o=1 until arready_i, then RDATA; arvalid_o SHALL NOT drop before the handshake.
REQ-026 RDATA: rready_o=1; on rvalid_i, capture rdata_i into rdata_o, go to DONE; err_o pulses in DONE if rresp_i[1] was 1.
REQ-027 Writes SHALL NOT modify rdata_o; rdata_o holds its last read value indefinitely.
REQ-028 DONE SHALL last exactly one cycle, ignore req_i, and return to IDLE.
REQ-029 Valid outputs SHALL be registered; address/data outputs SHALL remain stable while their valid is high.
REQ-030 At most one AXI transaction SHALL be outstanding; no IDs and no bursts.
REQ-031 Minimum latency with zero-wait slave: read req -> DONE = 3 cycles; write req -> DONE = 3 cycles.
REQ-032 Input changes on req_i/addr_i/we_i/wdata_i outside IDLE SHALL have no effect.

Reset
REQ-033 On rst=1, state=IDLE; awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, err_o = 0; rdata_o = 0; latched regs = 0.
REQ-034 rst mid-transaction SHALL abort immediately to IDLE with all valids low the following cycle; the AXI slave is reset alongside.
REQ-035 After rst deassertion, a req_i=1 on the first cycle SHALL be accepted.

Verification
REQ-036 Read 0x1000_0004, slave returns 0xDEADBEEF OKAY with zero waits -> hold_o high 3 cycles, rdata_o=0xDEADBEEF in DONE, err_o=0.
REQ-037 Write 0x2000_0000 data 0x1234_5678, awready 3 cycles before wready -> awvalid drops after its handshake, wvalid stays until its own, WRESP entered once both complete, bready_o=1.
REQ-038 Read with arready delayed 5 cycles and rvalid 4 more -> araddr_o stable throughout, hold_o high until DONE.
REQ-039 Write returning bresp=2'b10 -> err_o single-cycle pulse in DONE; rdata_o unchanged.
REQ-040 rst asserted in RDATA -> next cycle state IDLE, rready_o=0, rdata_o=0, hold_o=req_i.
REQ-041 Back-to-back reads with req_i held high -> DONE ignores req_i, second read accepted in next IDLE cycle.

Source files
------------

// File: rtl/rib2axi_lite.sv
// rib2axi_lite: bridges a single-beat RIB slave access onto AXI4-Lite.
// One transaction is in flight at a time; the core is stalled through hold_o
// until the AXI response has been taken, then DONE spends one cycle
// presenting err_o and the freshly registered read data.
module rib2axi_lite #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // RIB slave side
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          hold_o,
  output logic          err_o,
  // AXI write address channel
  output logic [AW-1:0] awaddr_o,
  output logic [2:0]    awprot_o,
  output logic          awvalid_o,
  input  logic          awready_i,
  // AXI write data channel
  output logic [DW-1:0] wdata_o,
  output logic [3:0]    wstrb_o,
  output logic          wvalid_o,
  input  logic          wready_i,
  // AXI write response channel
  input  logic [1:0]    bresp_i,
  input  logic          bvalid_i,
  output logic          bready_o,
  // AXI read address channel
  output logic [AW-1:0] araddr_o,
  output logic [2:0]    arprot_o,
  output logic          arvalid_o,
  input  logic          arready_i,
  // AXI read data channel
  input  logic [DW-1:0] rdata_i,
  input  logic [1:0]    rresp_i,
  input  logic          rvalid_i,
  output logic          rready_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WADDR_DATA = 3'd1,
    WRESP      = 3'd2,
    RADDR      = 3'd3,
    RDATA      = 3'd4,
    DONE       = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          arvalid_q, arvalid_d;
  logic          bready_q, bready_d;
  logic          rready_q, rready_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // A channel counts as complete once its valid has dropped (handshake in an
  // earlier cycle) or its handshake is happening right now.
  logic aw_hs_s, w_hs_s, aw_complete_s, w_complete_s;

  // SLVERR (2'b10) and DECERR (2'b11) are the two error responses.
  function automatic logic resp_is_err(input logic [1:0] resp);
    resp_is_err = (resp == 2'b10) || (resp == 2'b11);
  endfunction

  assign aw_hs_s       = awvalid_q & awready_i;
  assign w_hs_s        = wvalid_q & wready_i;
  assign aw_complete_s = ~awvalid_q | aw_hs_s;
  assign w_complete_s  = ~wvalid_q | w_hs_s;

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state logic: walk one transaction through its AXI channels.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = we_i ? WADDR_DATA : RADDR;
        end else begin
          state_d = IDLE;
        end
      end
      WADDR_DATA: begin
        if (aw_complete_s && w_complete_s) begin
          state_d = WRESP;
        end else begin
          state_d = WADDR_DATA;
        end
      end
      WRESP: begin
        if (bvalid_i) begin
          state_d = DONE;
        end else begin
          state_d = WRESP;
        end
      end
      RADDR: begin
        if (arready_i) begin
          state_d = RDATA;
        end else begin
          state_d = RADDR;
        end
      end
      RDATA: begin
        if (rvalid_i) begin
          state_d = DONE;
        end else begin
          state_d = RDATA;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the latched request.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          we_d      = we_i;
          awvalid_d = we_i;
          wvalid_d  = we_i;
          arvalid_d = ~we_i;
        end else begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          arvalid_d = 1'b0;
        end
      end
      WADDR_DATA: begin
        if (aw_hs_s) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (w_hs_s) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (aw_complete_s && w_complete_s) begin
          bready_d = 1'b1;
        end else begin
          bready_d = 1'b0;
        end
      end
      WRESP: begin
        if (bvalid_i) begin
          bready_d = 1'b0;
          err_d    = resp_is_err(bresp_i);
        end else begin
          bready_d = 1'b1;
        end
      end
      RADDR: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      RDATA: begin
        if (rvalid_i) begin
          rready_d = 1'b0;
          err_d    = resp_is_err(rresp_i);
          // Only a read ever reaches RDATA; the guard keeps writes from
          // touching the read-data register even if the state were corrupted.
          if (!we_q) begin
            rdata_d = rdata_i;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          rready_d = 1'b1;
        end
      end
      DONE: begin
        err_d = 1'b0;
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        bready_d  = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  // Core stall: follows req_i in IDLE so the request is held the same cycle.
  always_comb begin
    hold_o = 1'b0;
    case (state_q)
      IDLE:       hold_o = req_i;
      WADDR_DATA: hold_o = 1'b1;
      WRESP:      hold_o = 1'b1;
      RADDR:      hold_o = 1'b1;
      RDATA:      hold_o = 1'b1;
      DONE:       hold_o = 1'b0;
      default:    hold_o = 1'b0;
    endcase
  end

  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign awaddr_o  = addr_q;
  assign awprot_o  = 3'b000;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = 4'hF;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;
  assign araddr_o  = addr_q;
  assign arprot_o  = 3'b000;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;

endmodule
